// File: rtl/ode_ram7_ctrl.sv
// ode_ram7_ctrl: sequencer/arbiter for the 7-word record RAM (96 x 32) that
// holds ODE stage results. The producer writes one whole record (7 words)
// in a single cycle. The consumer reads one record as 7 words, one per cycle.
//
// Optional feature: define RAM7_RR_ARB_EN for round-robin arbitration when
// both sides request together. Without it, a write always wins a tie.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 synchronous flush of all stored records
//   wr_req / wr_ack       record write request / one-cycle write strobe
//   rd_req, rd_rec        record read request and record index
//   rd_busy               read stream in progress
//   rd_err                one-cycle pulse when the requested index is not stored
//   rd_valid/rd_word/rd_last  read data qualifiers, aligned to RAM dataout
//   ram_cs/we/oe          RAM strobes
//   ram_addr_in/out       RAM write base / read word address
//   rec_count, full, empty  fill level
module ode_ram7_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 96,
  parameter int REC_WORDS  = 7,
  parameter int MAX_RECS   = RAM_DEPTH / REC_WORDS,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_req,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [CNT_WIDTH-1:0]  rd_rec,
  output logic                  rd_busy,
  output logic                  rd_err,
  output logic                  rd_valid,
  output logic [2:0]            rd_word,
  output logic                  rd_last,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [CNT_WIDTH-1:0]  rec_count,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [2:0] LAST_WORD = 3'(REC_WORDS - 1);

  state_t state, nxt;
  logic [2:0] wcnt;
  logic wr_ok, rd_ok, pick_wr, grant_wr, grant_rd, rd_bad, issue;

  // x*7 as (x<<3)-x at address width
  function automatic logic [ADDR_WIDTH-1:0] x7(input logic [CNT_WIDTH-1:0] x);
    logic [ADDR_WIDTH-1:0] w;
    w = ADDR_WIDTH'(x);
    return (w << 3) - w;
  endfunction

  assign full  = (rec_count == CNT_WIDTH'(MAX_RECS));
  assign empty = (rec_count == '0);

  assign wr_ok  = wr_req & ~full & ~clear;
  assign rd_ok  = rd_req & ~clear;
  assign rd_bad = (rd_rec >= rec_count);

`ifdef RAM7_RR_ARB_EN
  // 0 = write granted last, 1 = read granted last; resets to 1 so a write
  // wins the first tie.
  logic last_grant;
  assign pick_wr = wr_ok & (~rd_ok | last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= 1'b1;
    else if (grant_wr) last_grant <= 1'b0;
    else if (grant_rd) last_grant <= 1'b1;
  end
`else
  assign pick_wr = wr_ok;
`endif

  assign grant_wr = (state == IDLE) & pick_wr;
  assign grant_rd = (state == IDLE) & rd_ok & ~pick_wr;
  assign issue    = (state == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    wr_ack  = 1'b0;
    rd_busy = 1'b0;
    ram_we  = 1'b0;
    ram_cs  = rd_valid;  // trailing cycle keeps dataout driven
    ram_oe  = rd_valid;
    case (state)
      IDLE: begin
        if (grant_wr)                nxt = WRITE;
        else if (grant_rd && !rd_bad) nxt = READ;
      end
      WRITE: begin
        wr_ack = 1'b1;
        ram_cs = 1'b1;
        ram_we = 1'b1;
        nxt    = IDLE;
      end
      READ: begin
        rd_busy = 1'b1;
        ram_cs  = 1'b1;
        ram_oe  = 1'b1;
        if (clear || wcnt == LAST_WORD) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt         <= '0;
      rec_count    <= '0;
      ram_addr_in  <= '0;
      ram_addr_out <= '0;
      rd_err       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_word      <= '0;
    end else begin
      if (clear)               rec_count <= '0;
      else if (state == WRITE) rec_count <= rec_count + 1'b1;

      if (grant_wr) ram_addr_in <= x7(rec_count);

      // Read address walks base..base+6 and holds the last issued word.
      if (grant_rd && !rd_bad) begin
        ram_addr_out <= x7(rd_rec);
        wcnt         <= '0;
      end else if (issue && nxt == READ) begin
        ram_addr_out <= ram_addr_out + 1'b1;
        wcnt         <= wcnt + 3'd1;
      end

      rd_err <= grant_rd & rd_bad;

      // One-cycle RAM read latency
      rd_valid <= issue;
      rd_word  <= issue ? wcnt : 3'd0;
    end
  end

  assign rd_last = rd_valid & (rd_word == LAST_WORD);

endmodule

// File: tb/tb_ode_ram7_ctrl.sv
module tb_ode_ram7_ctrl;
  localparam int AW = 32;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n, clear, wr_req, wr_ack, rd_req, rd_busy, rd_err, rd_valid, rd_last;
  logic ram_cs, ram_we, ram_oe, full, empty;
  logic [CW-1:0] rd_rec, rec_count;
  logic [2:0] rd_word;
  logic [AW-1:0] ram_addr_in, ram_addr_out;

  always #5 clk = ~clk;

  ode_ram7_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_rec(rd_rec), .rd_busy(rd_busy), .rd_err(rd_err),
    .rd_valid(rd_valid), .rd_word(rd_word), .rd_last(rd_last), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr_in(ram_addr_in),
    .ram_addr_out(ram_addr_out), .rec_count(rec_count), .full(full), .empty(empty)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Packed view: ack we cs oe busy vld word[3] last err full empty cnt[5] ain[8] aout[8]
  typedef logic [33:0] snap_t;

  function automatic snap_t mk(input logic ack, we, cs, oe, busy, vld,
                               input logic [2:0] word, input logic err,
                               input logic [4:0] cnt, input logic [7:0] ain, aout);
    logic last, fl, em;
    last = vld && (word == 3'd6);
    fl   = (cnt == 5'd13);
    em   = (cnt == 5'd0);
    return {ack, we, cs, oe, busy, vld, word, last, err, fl, em, cnt, ain, aout};
  endfunction

  function automatic snap_t act();
    return {wr_ack, ram_we, ram_cs, ram_oe, rd_busy, rd_valid, rd_word, rd_last,
            rd_err, full, empty, rec_count, ram_addr_in[7:0], ram_addr_out[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [4:0] rec;
    snap_t      exp;
  } vec_t;

  vec_t vt[16];
  logic [3:0] gseq, gexp;
  int ng, nacks, nwe, nvld, idx;
  logic prev_busy;

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_rec = '0;

    //                 ack we cs oe bsy vld word err cnt ain aout
    vt[0]  = '{1,0,0, mk(1,1,1,0,0,0,3'd0,0,5'd0, 8'd0, 8'd0)};
    vt[1]  = '{1,0,0, mk(0,0,0,0,0,0,3'd0,0,5'd1, 8'd0, 8'd0)};
    vt[2]  = '{1,0,0, mk(1,1,1,0,0,0,3'd0,0,5'd1, 8'd7, 8'd0)};
    vt[3]  = '{1,0,0, mk(0,0,0,0,0,0,3'd0,0,5'd2, 8'd7, 8'd0)};
    vt[4]  = '{1,0,0, mk(1,1,1,0,0,0,3'd0,0,5'd2, 8'd14,8'd0)};
    vt[5]  = '{0,0,0, mk(0,0,0,0,0,0,3'd0,0,5'd3, 8'd14,8'd0)};
    vt[6]  = '{0,1,1, mk(0,0,1,1,1,0,3'd0,0,5'd3, 8'd14,8'd7)};
    vt[7]  = '{0,0,0, mk(0,0,1,1,1,1,3'd0,0,5'd3, 8'd14,8'd8)};
    vt[8]  = '{0,0,0, mk(0,0,1,1,1,1,3'd1,0,5'd3, 8'd14,8'd9)};
    vt[9]  = '{0,0,0, mk(0,0,1,1,1,1,3'd2,0,5'd3, 8'd14,8'd10)};
    vt[10] = '{0,0,0, mk(0,0,1,1,1,1,3'd3,0,5'd3, 8'd14,8'd11)};
    vt[11] = '{0,0,0, mk(0,0,1,1,1,1,3'd4,0,5'd3, 8'd14,8'd12)};
    vt[12] = '{0,0,0, mk(0,0,1,1,1,1,3'd5,0,5'd3, 8'd14,8'd13)};
    vt[13] = '{0,0,0, mk(0,0,1,1,0,1,3'd6,0,5'd3, 8'd14,8'd13)};
    vt[14] = '{0,1,3, mk(0,0,0,0,0,0,3'd0,1,5'd3, 8'd14,8'd13)};
    vt[15] = '{0,0,0, mk(0,0,0,0,0,0,3'd0,0,5'd3, 8'd14,8'd13)};

    #12;
    check("reset_state", 64'(act()), 64'(mk(0,0,0,0,0,0,3'd0,0,5'd0,8'd0,8'd0)));
    rst_n = 1'b1;
    step();

    // 3 writes, read of record 1, out-of-range read
    for (int i = 0; i < 16; i++) begin
      wr_req = vt[i].wr; rd_req = vt[i].rd; rd_rec = vt[i].rec;
      step();
      check($sformatf("vec%0d", i), 64'(act()), 64'(vt[i].exp));
    end

    // Fill to capacity; each ack lands at index*7
    idx = 3;
    wr_req = 1'b1;
    for (int c = 0; c < 100 && !full; c++) begin
      step();
      if (wr_ack) begin
        check($sformatf("fill_addr%0d", idx), 64'(ram_addr_in), 64'(idx * 7));
        idx++;
      end
    end
    check("fill_count", 64'(idx), 64'd13);
    check("full_flags", 64'({full, empty, rec_count}), 64'({1'b1, 1'b0, 5'd13}));

    // Write while full: no ack, no RAM write for 20 cycles
    nacks = 0; nwe = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (wr_ack) nacks++;
      if (ram_we) nwe++;
    end
    check("full_no_ack_we", 64'(nacks + nwe), 64'd0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_count", 64'({rec_count, empty, full}), 64'({5'd0, 1'b1, 1'b0}));
    step();
    check("post_clear_write", 64'({wr_ack, ram_addr_in[7:0]}), 64'({1'b1, 8'd0}));
    wr_req = 1'b0;
    step();

    // Simultaneous requests from reset: record the first 4 grants (1 = read)
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    wr_req = 1'b1; rd_req = 1'b1; rd_rec = 5'd0;
    ng = 0; gseq = '0; prev_busy = 1'b0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      step();
      if (wr_ack) begin gseq[ng] = 1'b0; ng++; end
      else if ((rd_busy && !prev_busy) || rd_err) begin gseq[ng] = 1'b1; ng++; end
      prev_busy = rd_busy;
    end
`ifdef RAM7_RR_ARB_EN
    gexp = 4'b1010;
`else
    gexp = 4'b0000;
`endif
    check("tie_grant_count", 64'(ng), 64'd4);
    check("tie_grant_order", 64'(gseq), 64'(gexp));
    wr_req = 1'b0; rd_req = 1'b0;
    for (int c = 0; c < 12; c++) step();

    // Async reset in the middle of a read
    rd_req = 1'b1; rd_rec = 5'd0;
    step();
    rd_req = 1'b0;
    check("midread_busy", 64'(rd_busy), 64'd1);
    for (int c = 0; c < 3; c++) step();
    check("midread_addr", 64'(ram_addr_out), 64'd3);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 64'(act()), 64'(mk(0,0,0,0,0,0,3'd0,0,5'd0,8'd0,8'd0)));
    step();
    rst_n = 1'b1;
    nvld = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rd_valid || ram_oe) nvld++;
    end
    check("no_valid_after_reset", 64'(nvld), 64'd0);
    check("count_after_reset", 64'(rec_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
